lcd_cfah_bus_ctrl: RTL and testbench
====================================

// Module: lcd_cfah_bus_ctrl
// PURPOSE
// - Sequences the CFAH character-LCD parallel bus (rs/rw/en/data) for the zipcpu AXI4-lite top.
// - Runs a power-up init ROM, then serves single-byte write/read requests from a valid/ready port.
// - Enforces setup, enable-pulse and hold timing with counters.
// - After each write and each data read, polls the busy flag until it is clear or a timeout expires.
// PARAMETERS
// - G_T_SETUP       2       clk cycles rs/rw/data stable before en rises (>=1)
// - G_T_EN_HIGH     12      clk cycles en held high (>=2)
// - G_T_HOLD        2       clk cycles rs/rw/data held after en falls (>=1)
// - G_PWRUP_WAIT    750000  clk cycles after reset before first init command
// - G_BUSY_TIMEOUT  100000  max busy-poll reads per command before abort
// - G_INIT_EN       1       1: run init ROM; 0: skip to idle after G_PWRUP_WAIT
// PORTS
// - clk            in   1  system clock
// - rst            in   1  synchronous reset, active-high
// - i_cmd_val      in   1  request valid
// - o_cmd_rdy      out  1  request accepted when i_cmd_val & o_cmd_rdy
// - i_cmd_rs       in   1  0: instruction/status register, 1: data register
// - i_cmd_rnw      in   1  1: read access, 0: write access
// - i_cmd_data     in   8  write byte
// - o_rsp_val      out  1  one-cycle pulse, read data valid
// - o_rsp_data     out  8  sampled read byte, held until next read
// - o_timeout      out  1  one-cycle pulse, busy poll aborted
// - o_init_done    out  1  level; init sequence complete
// - o_lcd_rs       out  1  LCD register select
// - o_lcd_rw       out  1  LCD read/not-write
// - o_lcd_en       out  1  LCD enable strobe
// - o_lcd_data     out  8  LCD bus drive value
// - o_lcd_data_oe  out  1  1: drive bus; top-level tristate uses it
// - i_lcd_data     in   8  LCD bus sampled value
// - o_lcd_on       out  1  LCD power/backlight; 1 once out of reset
// BEHAVIOUR
// - Reset (any state, any cycle): all outputs 0 at the next edge, except o_lcd_on=0 during rst and 1 after.
//   - Effects: en drops immediately, oe=0, counters cleared, FSM to S_PWRUP, o_init_done=0.
// - FSM states: S_PWRUP -> S_INIT -> S_IDLE -> S_ACCESS -> S_POLL -> S_IDLE.
// - S_PWRUP: counts G_PWRUP_WAIT cycles.
//   - G_INIT_EN=1: go to S_INIT, rom index 0. G_INIT_EN=0: o_init_done=1, go to S_IDLE.
// - S_INIT: issues ROM writes (rs=0): 0x38,0x38,0x38,0x08,0x01,0x06,0x0C.
//   - Each ROM write goes through S_ACCESS then S_POLL.
//   - After index 6: o_init_done=1, go to S_IDLE. o_cmd_rdy=0 throughout.
// - S_IDLE: o_cmd_rdy=1 (combinational from state). On handshake, capture rs/rnw/data and go to S_ACCESS.
// - Bus cycle (S_ACCESS and each poll read):
//   - Setup phase: G_T_SETUP cycles, rs/rw valid, en=0.
//   - Enable phase: G_T_EN_HIGH cycles, en=1.
//   - Hold phase: G_T_HOLD cycles, en=0, rs/rw unchanged.
//   - Write: oe=1 with data through all three phases.
//   - Read: oe=0; i_lcd_data is sampled on the last en-high cycle.
//   - Bus-cycle length = G_T_SETUP+G_T_EN_HIGH+G_T_HOLD cycles.
// - After a user read: o_rsp_val pulses on the cycle after the hold phase ends.
//   - Status read (rs=0, rnw=1): return to S_IDLE, no poll.
//   - Data read (rs=1): go to S_POLL.
// - After a write: go to S_POLL.
// - S_POLL: repeated status reads (rs=0, rw=1) back to back.
//   - Sampled bit7=0: go to S_IDLE (or next ROM entry).
//   - Poll reads never raise o_rsp_val.
//   - Poll count reaches G_BUSY_TIMEOUT with bit7 still 1: o_timeout pulses 1 cycle, then S_IDLE.
//   - A timeout during init continues with the next ROM entry. o_init_done still rises.
// - Only one request is outstanding at a time; i_cmd_val outside S_IDLE is ignored (rdy=0).
// - Timing counters are wide enough for the largest parameter.
//   - Poll counter saturates; no wrap.
// STRUCTURE
// - lcd_cfah_pkg: state enum, init ROM constant array (7x8b), C_BUSY_BIT=7, counter-width function.
// - Sub-module lcd_cfah_bus_cycle: start/rnw/rs/wdata in; setup/en/hold timing; drives pins; outputs done + rdata.
//   - The top FSM reuses it for user accesses, init writes and polls.
// TESTING (G_T_SETUP=2, G_T_EN_HIGH=4, G_T_HOLD=2, G_PWRUP_WAIT=20, G_BUSY_TIMEOUT=8, LCD_CFAH_emul on bus)
// - Init: release rst, emul busy duration 5 -> emul logs 38,38,38,08,01,06,0C in order, then o_init_done=1.
// - Write data: rs=1 rnw=0 data 0x41 -> en high exactly 4 cycles, oe=1 for 8 cycles, emul receives 0x41.
//   - Then status polls occur, then o_cmd_rdy=1.
// - Data read: SEL_LCD=1, WDATA_LCD=0x5A, rs=1 rnw=1 -> o_rsp_val pulse with o_rsp_data=0x5A.
//   - Poll follows; oe=0 throughout.
// - Timeout: busy duration 0xFF, write 0x01 -> o_timeout pulses after 8 poll reads, o_rsp_val stays 0, rdy returns to 1.
// - Reset mid-access: assert rst while en=1 -> en=0, oe=0, rdy=0 next edge; full init replays after release.
// - Back-pressure: hold i_cmd_val=1 with two commands -> second accepted only after first poll clears; no loss, no duplicate.

Source files
------------

// File: rtl/lcd_cfah_pkg.sv
// CFAH character-LCD bus controller: shared types and constants.
// Holds the FSM encodings, the power-up command ROM and width helpers.
package lcd_cfah_pkg;

  typedef enum logic [2:0] {
    S_PWRUP,
    S_INIT,
    S_IDLE,
    S_ACCESS,
    S_POLL
  } state_t;

  typedef enum logic [1:0] {
    P_IDLE,
    P_SETUP,
    P_EN,
    P_HOLD
  } phase_t;

  localparam int C_BUSY_BIT = 7;

  localparam logic [2:0] C_ROM_LAST = 3'd6;

  // Entry 0 sits in the low byte; the leftmost byte is issued last.
  localparam logic [6:0][7:0] C_INIT_ROM = {
    8'h0C, 8'h06, 8'h01, 8'h08,
    8'h38, 8'h38, 8'h38
  };

  function automatic int unsigned cnt_width(
    input int unsigned v
  );
    return (v < 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/lcd_cfah_bus_ctrl_if.sv
// Request/response port of the CFAH LCD bus controller.
// master drives requests, slave answers them.
interface lcd_cfah_bus_ctrl_if;

  logic       i_cmd_val;
  logic       o_cmd_rdy;
  logic       i_cmd_rs;
  logic       i_cmd_rnw;
  logic [7:0] i_cmd_data;
  logic       o_rsp_val;
  logic [7:0] o_rsp_data;
  logic       o_timeout;

  modport master (
    output i_cmd_val,
    output i_cmd_rs,
    output i_cmd_rnw,
    output i_cmd_data,
    input  o_cmd_rdy,
    input  o_rsp_val,
    input  o_rsp_data,
    input  o_timeout
  );

  modport slave (
    input  i_cmd_val,
    input  i_cmd_rs,
    input  i_cmd_rnw,
    input  i_cmd_data,
    output o_cmd_rdy,
    output o_rsp_val,
    output o_rsp_data,
    output o_timeout
  );

endinterface

// File: rtl/lcd_cfah_bus_cycle.sv
// One timed LCD bus cycle: setup, enable pulse, hold.
// Read data is captured on the last enable-high cycle.
module lcd_cfah_bus_cycle
  import lcd_cfah_pkg::*;
#(
  parameter int unsigned G_T_SETUP   = 2,
  parameter int unsigned G_T_EN_HIGH = 12,
  parameter int unsigned G_T_HOLD    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rnw,
  input  logic       rs,
  input  logic [7:0] wdata,
  output logic       active,
  output logic       done,
  output logic [7:0] rdata,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data,
  output logic       lcd_data_oe,
  input  logic [7:0] lcd_din
);

  localparam int unsigned C_MAX1 =
    (G_T_SETUP > G_T_EN_HIGH) ? G_T_SETUP : G_T_EN_HIGH;
  localparam int unsigned C_MAX =
    (C_MAX1 > G_T_HOLD) ? C_MAX1 : G_T_HOLD;
  localparam int CW = cnt_width(C_MAX);

  phase_t        phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rs_q, rw_q;
  logic [7:0]    wd_q;
  logic          smp;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= P_IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      rw_q    <= 1'b0;
      wd_q    <= '0;
      rdata   <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      if (phase_q == P_IDLE && start) begin
        rs_q <= rs;
        rw_q <= rnw;
        wd_q <= wdata;
      end
      if (smp) rdata <= lcd_din;
    end
  end

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q + CW'(1);
    done    = 1'b0;
    smp     = 1'b0;
    unique case (phase_q)
      P_IDLE: begin
        cnt_d = '0;
        if (start) phase_d = P_SETUP;
      end
      P_SETUP: begin
        if (cnt_q == CW'(G_T_SETUP - 1)) begin
          phase_d = P_EN;
          cnt_d   = '0;
        end
      end
      P_EN: begin
        if (cnt_q == CW'(G_T_EN_HIGH - 1)) begin
          phase_d = P_HOLD;
          cnt_d   = '0;
          smp     = 1'b1;
        end
      end
      P_HOLD: begin
        if (cnt_q == CW'(G_T_HOLD - 1)) begin
          phase_d = P_IDLE;
          cnt_d   = '0;
          done    = 1'b1;
        end
      end
      default: begin
        phase_d = P_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign active      = (phase_q != P_IDLE);
  assign lcd_rs      = active & rs_q;
  assign lcd_rw      = active & rw_q;
  assign lcd_en      = (phase_q == P_EN);
  assign lcd_data_oe = active & ~rw_q;
  assign lcd_data    = lcd_data_oe ? wd_q : 8'h00;

endmodule

// File: rtl/lcd_cfah_bus_ctrl.sv
// CFAH LCD bus sequencer: power-up init ROM, then single-byte
// requests, each followed by busy-flag polling with timeout.
module lcd_cfah_bus_ctrl
  import lcd_cfah_pkg::*;
#(
  parameter int unsigned G_T_SETUP      = 2,
  parameter int unsigned G_T_EN_HIGH    = 12,
  parameter int unsigned G_T_HOLD       = 2,
  parameter int unsigned G_PWRUP_WAIT   = 750000,
  parameter int unsigned G_BUSY_TIMEOUT = 100000,
  parameter int unsigned G_INIT_EN      = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  lcd_cfah_bus_ctrl_if.slave        cmd,
  output logic                      o_init_done,
  output logic                      o_lcd_rs,
  output logic                      o_lcd_rw,
  output logic                      o_lcd_en,
  output logic [7:0]                o_lcd_data,
  output logic                      o_lcd_data_oe,
  input  logic [7:0]                i_lcd_data,
  output logic                      o_lcd_on
);

  localparam int PWW = cnt_width(G_PWRUP_WAIT);
  localparam int PCW = cnt_width(G_BUSY_TIMEOUT);

  state_t         state_q, state_d;
  logic [PWW-1:0] pw_cnt_q;
  logic [PCW-1:0] poll_cnt_q;
  logic [2:0]     idx_q;
  logic           rs_q, rnw_q;
  logic [7:0]     wd_q;
  logic           init_done_q;
  logic           rsp_val_q, tout_q, lcd_on_q;
  logic [7:0]     rsp_data_q;

  logic           cmd_rdy;
  logic           bc_start, bc_rs, bc_rnw;
  logic           bc_active, bc_done;
  logic [7:0]     bc_rdata;
  logic           pw_last, poll_last;
  logic           fin, acc_rsp, tout, poll_inc;

  assign pw_last   = (pw_cnt_q == PWW'(G_PWRUP_WAIT - 1));
  assign poll_last = (poll_cnt_q == PCW'(G_BUSY_TIMEOUT - 1));

  lcd_cfah_bus_cycle #(
    .G_T_SETUP   (G_T_SETUP),
    .G_T_EN_HIGH (G_T_EN_HIGH),
    .G_T_HOLD    (G_T_HOLD)
  ) u_cycle (
    .clk         (clk),
    .rst         (rst),
    .start       (bc_start),
    .rnw         (bc_rnw),
    .rs          (bc_rs),
    .wdata       (wd_q),
    .active      (bc_active),
    .done        (bc_done),
    .rdata       (bc_rdata),
    .lcd_rs      (o_lcd_rs),
    .lcd_rw      (o_lcd_rw),
    .lcd_en      (o_lcd_en),
    .lcd_data    (o_lcd_data),
    .lcd_data_oe (o_lcd_data_oe),
    .lcd_din     (i_lcd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_PWRUP;
      pw_cnt_q    <= '0;
      poll_cnt_q  <= '0;
      idx_q       <= '0;
      rs_q        <= 1'b0;
      rnw_q       <= 1'b0;
      wd_q        <= '0;
      init_done_q <= 1'b0;
      rsp_val_q   <= 1'b0;
      rsp_data_q  <= '0;
      tout_q      <= 1'b0;
      lcd_on_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lcd_on_q  <= 1'b1;
      rsp_val_q <= acc_rsp;
      tout_q    <= tout;
      if (state_q == S_PWRUP) begin
        idx_q <= '0;
        if (!pw_last) pw_cnt_q <= pw_cnt_q + PWW'(1);
        else if (G_INIT_EN == 0) init_done_q <= 1'b1;
      end
      if (state_q == S_INIT) begin
        rs_q  <= 1'b0;
        rnw_q <= 1'b0;
        wd_q  <= C_INIT_ROM[idx_q];
      end
      if (state_q == S_IDLE && cmd.i_cmd_val) begin
        rs_q  <= cmd.i_cmd_rs;
        rnw_q <= cmd.i_cmd_rnw;
        wd_q  <= cmd.i_cmd_data;
      end
      if (state_q == S_ACCESS) poll_cnt_q <= '0;
      if (poll_inc) poll_cnt_q <= poll_cnt_q + PCW'(1);
      if (fin && !init_done_q) begin
        if (idx_q == C_ROM_LAST) init_done_q <= 1'b1;
        else idx_q <= idx_q + 3'd1;
      end
      if (acc_rsp) rsp_data_q <= bc_rdata;
    end
  end

  always_comb begin
    state_d  = state_q;
    cmd_rdy  = 1'b0;
    bc_start = 1'b0;
    bc_rs    = rs_q;
    bc_rnw   = rnw_q;
    fin      = 1'b0;
    acc_rsp  = 1'b0;
    tout     = 1'b0;
    poll_inc = 1'b0;
    unique case (state_q)
      S_PWRUP: begin
        if (pw_last)
          state_d = (G_INIT_EN != 0) ? S_INIT : S_IDLE;
      end
      S_INIT: state_d = S_ACCESS;
      S_IDLE: begin
        cmd_rdy = 1'b1;
        if (cmd.i_cmd_val) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        bc_start = ~bc_active;
        if (bc_done) begin
          acc_rsp = rnw_q;
          // status reads already carry the busy flag: no poll
          state_d = (rnw_q && !rs_q) ? S_IDLE : S_POLL;
        end
      end
      S_POLL: begin
        bc_start = ~bc_active;
        bc_rs    = 1'b0;
        bc_rnw   = 1'b1;
        if (bc_done) begin
          if (!bc_rdata[C_BUSY_BIT]) begin
            fin = 1'b1;
          end else if (poll_last) begin
            fin  = 1'b1;
            tout = 1'b1;
          end else begin
            poll_inc = 1'b1;
          end
        end
        if (fin) begin
          if (!init_done_q && idx_q != C_ROM_LAST)
            state_d = S_INIT;
          else
            state_d = S_IDLE;
        end
      end
      default: state_d = S_PWRUP;
    endcase
  end

  assign cmd.o_cmd_rdy  = cmd_rdy;
  assign cmd.o_rsp_val  = rsp_val_q;
  assign cmd.o_rsp_data = rsp_data_q;
  assign cmd.o_timeout  = tout_q;
  assign o_init_done    = init_done_q;
  assign o_lcd_on       = lcd_on_q;

endmodule

// File: tb/tb_lcd_cfah_bus_ctrl.sv
// Bench for lcd_cfah_bus_ctrl with a behavioural CFAH LCD emulator
// and a request-level model of expected writes, polls and timeouts.
module tb_lcd_cfah_bus_ctrl;

  localparam int T_SETUP = 2;
  localparam int T_EN    = 4;
  localparam int T_HOLD  = 2;
  localparam int PWRUP   = 20;
  localparam int TMO     = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       init_done;
  logic       lcd_rs, lcd_rw, lcd_en, lcd_oe, lcd_on;
  logic [7:0] lcd_dout, lcd_din;

  lcd_cfah_bus_ctrl_if bus();

  always #5 clk = ~clk;

  lcd_cfah_bus_ctrl #(
    .G_T_SETUP      (T_SETUP),
    .G_T_EN_HIGH    (T_EN),
    .G_T_HOLD       (T_HOLD),
    .G_PWRUP_WAIT   (PWRUP),
    .G_BUSY_TIMEOUT (TMO),
    .G_INIT_EN      (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd           (bus),
    .o_init_done   (init_done),
    .o_lcd_rs      (lcd_rs),
    .o_lcd_rw      (lcd_rw),
    .o_lcd_en      (lcd_en),
    .o_lcd_data    (lcd_dout),
    .o_lcd_data_oe (lcd_oe),
    .i_lcd_data    (lcd_din),
    .o_lcd_on      (lcd_on)
  );

  // LCD emulator: busy for busy_dur status reads after each write
  int         busy_dur  = 5;
  int         busy_left = 0;
  int         stat_reads = 0;
  logic       sel_lcd   = 1'b1;
  logic [7:0] wdata_lcd = 8'h00;
  logic [8:0] wlog[$];

  assign lcd_din = lcd_rs ? (sel_lcd ? wdata_lcd : 8'h00)
                          : {(busy_left != 0), 7'd0};

  always @(negedge lcd_en) begin
    if (!rst) begin
      if (!lcd_rw) begin
        wlog.push_back({lcd_rs, lcd_dout});
        busy_left = busy_dur;
      end else if (!lcd_rs) begin
        stat_reads++;
        if (busy_left > 0) busy_left--;
      end
    end
  end

  int         en_run = 0, en_last = 0;
  int         oe_run = 0, oe_last = 0, oe_cycles = 0;
  int         rsp_cnt = 0, tout_cnt = 0;
  logic [7:0] rsp_last = 8'h00;

  always @(negedge clk) begin
    if (lcd_en) en_run++;
    else if (en_run != 0) begin en_last = en_run; en_run = 0; end
    if (lcd_oe) begin oe_run++; oe_cycles++; end
    else if (oe_run != 0) begin oe_last = oe_run; oe_run = 0; end
    if (bus.o_rsp_val) begin rsp_cnt++; rsp_last = bus.o_rsp_data; end
    if (bus.o_timeout) tout_cnt++;
  end

  int checks = 0;
  int errors = 0;

  logic [7:0] rom_exp [7] = '{8'h38, 8'h38, 8'h38, 8'h08,
                              8'h01, 8'h06, 8'h0C};

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rdy(input string tag);
    int n = 0;
    while (bus.o_cmd_rdy !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(bus.o_cmd_rdy), 32'd1);
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (init_done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(init_done), 32'd1);
  endtask

  task automatic issue(input logic rs, input logic rnw,
                       input logic [7:0] d);
    @(negedge clk);
    bus.i_cmd_rs   = rs;
    bus.i_cmd_rnw  = rnw;
    bus.i_cmd_data = d;
    bus.i_cmd_val  = 1'b1;
    wait_rdy("hs_rdy");
    @(posedge clk);
    #1 bus.i_cmd_val = 1'b0;
    @(negedge clk);
    wait_rdy("done_rdy");
    repeat (3) @(negedge clk);
  endtask

  task automatic check_init(input string tag, input int w0,
                            input int s0);
    check({tag, "_nwrites"}, 32'(wlog.size() - w0), 32'd7);
    for (int i = 0; i < 7; i++)
      if (w0 + i < wlog.size())
        check({tag, "_rom"}, 32'(wlog[w0 + i]),
              32'({1'b0, rom_exp[i]}));
    check({tag, "_polls"}, 32'(stat_reads - s0), 32'd42);
  endtask

  initial begin
    int w0, s0, r0, t0, o0, b, exp_polls;
    logic [7:0] d, d2;
    logic       rs;

    bus.i_cmd_val  = 1'b0;
    bus.i_cmd_rs   = 1'b0;
    bus.i_cmd_rnw  = 1'b0;
    bus.i_cmd_data = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_rdy",     32'(bus.o_cmd_rdy), 32'd0);
    check("rst_en",      32'(lcd_en),        32'd0);
    check("rst_oe",      32'(lcd_oe),        32'd0);
    check("rst_done",    32'(init_done),     32'd0);
    check("rst_lcd_on",  32'(lcd_on),        32'd0);
    check("rst_rsp_val", 32'(bus.o_rsp_val), 32'd0);
    check("rst_timeout", 32'(bus.o_timeout), 32'd0);

    busy_dur = 5;
    w0 = wlog.size();
    s0 = stat_reads;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("lcd_on_after_rst", 32'(lcd_on), 32'd1);
    check("pwrup_rdy_low", 32'(bus.o_cmd_rdy), 32'd0);
    wait_init("init_done");
    check_init("init", w0, s0);
    @(negedge clk);
    check("init_rdy", 32'(bus.o_cmd_rdy), 32'd1);

    // random writes with busy times below the timeout
    for (int k = 0; k < 6; k++) begin
      b  = $urandom_range(0, TMO - 1);
      d  = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      if (k == 0) begin b = 5; d = 8'h41; rs = 1'b1; end
      busy_dur = b;
      w0 = wlog.size(); s0 = stat_reads;
      t0 = tout_cnt; r0 = rsp_cnt;
      issue(rs, 1'b0, d);
      exp_polls = b + 1;
      check("wr_nlog", 32'(wlog.size() - w0), 32'd1);
      if (wlog.size() > w0)
        check("wr_data", 32'(wlog[w0]), 32'({rs, d}));
      check("wr_en_len", 32'(en_last), 32'(T_EN));
      check("wr_oe_len", 32'(oe_last),
            32'(T_SETUP + T_EN + T_HOLD));
      check("wr_polls", 32'(stat_reads - s0), 32'(exp_polls));
      check("wr_tout", 32'(tout_cnt - t0), 32'd0);
      check("wr_rsp", 32'(rsp_cnt - r0), 32'd0);
    end

    // data reads
    sel_lcd = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d = 8'($urandom_range(0, 255));
      if (k == 0) d = 8'h5A;
      wdata_lcd = d;
      s0 = stat_reads; r0 = rsp_cnt; o0 = oe_cycles;
      issue(1'b1, 1'b1, 8'h00);
      check("rd_rsp_cnt", 32'(rsp_cnt - r0), 32'd1);
      check("rd_rsp_data", 32'(rsp_last), 32'(d));
      check("rd_port_data", 32'(bus.o_rsp_data), 32'(d));
      check("rd_oe", 32'(oe_cycles - o0), 32'd0);
      check("rd_polls", 32'(stat_reads - s0), 32'd1);
    end

    // status read returns the flag directly without polling
    s0 = stat_reads; r0 = rsp_cnt;
    issue(1'b0, 1'b1, 8'h00);
    check("st_rsp_cnt", 32'(rsp_cnt - r0), 32'd1);
    check("st_rsp_data", 32'(rsp_last), 32'h00);
    check("st_reads", 32'(stat_reads - s0), 32'd1);

    // busy never clears
    busy_dur = 255;
    s0 = stat_reads; r0 = rsp_cnt; t0 = tout_cnt;
    issue(1'b0, 1'b0, 8'h01);
    check("to_tout", 32'(tout_cnt - t0), 32'd1);
    check("to_polls", 32'(stat_reads - s0), 32'(TMO));
    check("to_rsp", 32'(rsp_cnt - r0), 32'd0);

    // back-pressure: two commands with i_cmd_val held high
    busy_dur = 3;
    d  = 8'($urandom_range(0, 255));
    d2 = 8'($urandom_range(0, 255));
    w0 = wlog.size(); s0 = stat_reads;
    @(negedge clk);
    bus.i_cmd_rs   = 1'b1;
    bus.i_cmd_rnw  = 1'b0;
    bus.i_cmd_data = d;
    bus.i_cmd_val  = 1'b1;
    wait_rdy("bp_a_rdy");
    @(posedge clk);
    #1 bus.i_cmd_data = d2;
    @(negedge clk);
    wait_rdy("bp_b_rdy");
    check("bp_polls_before_b", 32'(stat_reads - s0), 32'd4);
    @(posedge clk);
    #1 bus.i_cmd_val = 1'b0;
    @(negedge clk);
    wait_rdy("bp_done");
    repeat (3) @(negedge clk);
    check("bp_nlog", 32'(wlog.size() - w0), 32'd2);
    if (wlog.size() >= w0 + 2) begin
      check("bp_first", 32'(wlog[w0]), 32'({1'b1, d}));
      check("bp_second", 32'(wlog[w0 + 1]), 32'({1'b1, d2}));
    end

    // reset in the middle of an enable pulse
    busy_dur = 5;
    @(negedge clk);
    bus.i_cmd_rs   = 1'b1;
    bus.i_cmd_rnw  = 1'b0;
    bus.i_cmd_data = 8'h77;
    bus.i_cmd_val  = 1'b1;
    wait_rdy("mr_rdy");
    @(posedge clk);
    #1 bus.i_cmd_val = 1'b0;
    for (int n = 0; n < 50 && lcd_en !== 1'b1; n++)
      @(negedge clk);
    check("mr_en_seen", 32'(lcd_en), 32'd1);
    w0 = wlog.size(); s0 = stat_reads;
    rst = 1'b1;
    @(negedge clk);
    check("mr_en", 32'(lcd_en), 32'd0);
    check("mr_oe", 32'(lcd_oe), 32'd0);
    check("mr_rdy_low", 32'(bus.o_cmd_rdy), 32'd0);
    check("mr_done_low", 32'(init_done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_init("mr_init_done");
    check_init("mr_init", w0, s0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
